// File: rtl/new_mul.sv
// Two-stage pipelined integer multiplier: operand registers, then partial products
// summed by an adder tree into a registered product. Define NEW_MUL_SIGNED_EN for two's complement.
module new_mul #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               ck,
  output logic [2*WIDTH-1:0] mul,
  input  logic               rst_n
);

  localparam int PW = 2 * WIDTH;

`ifdef NEW_MUL_SIGNED_EN
  // Baugh-Wooley correction: the inverted sign-row bits are balanced by these two ones.
  localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`endif

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_mul;
  logic [PW-1:0]    w_sum;

  // Stage 1: capture operands.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Partial products feed a heap-ordered adder tree: leaves at [WIDTH..2*WIDTH-1], root at [1].
  always_comb begin : pp_tree
    logic [WIDTH-1:0] w_row;
    logic [PW-1:0]    w_node [2*WIDTH];
    w_row = '0;
    for (int n = 0; n < 2 * WIDTH; n++) begin
      w_node[n] = '0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_row = r_a & {WIDTH{r_b[i]}};
`ifdef NEW_MUL_SIGNED_EN
      if (i == WIDTH - 1) begin
        w_row[WIDTH-2:0] = ~w_row[WIDTH-2:0];
      end else begin
        w_row[WIDTH-1] = ~w_row[WIDTH-1];
      end
`endif
      w_node[WIDTH + i] = PW'(w_row) << i;
    end
    for (int k = WIDTH - 1; k >= 1; k--) begin
      w_node[k] = w_node[2 * k] + w_node[2 * k + 1];
    end
`ifdef NEW_MUL_SIGNED_EN
    w_sum = w_node[1] + BW_CORR;
`else
    w_sum = w_node[1];
`endif
  end

  // Stage 2: register the product.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_mul <= '0;
    end else begin
      r_mul <= w_sum;
    end
  end

  assign mul = r_mul;

endmodule

// File: tb/tb_new_mul.sv
// Self-checking bench for new_mul: random and directed operands against an
// arithmetic reference with a queue standing in for the two-edge latency.
module tb_new_mul;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ck;
  logic [PW-1:0] mul;
  logic          rst_n;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];

  new_mul #(.WIDTH(W)) dut (
    .a    (a),
    .b    (b),
    .ck   (ck),
    .mul  (mul),
    .rst_n(rst_n)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef NEW_MUL_SIGNED_EN
    int sx;
    int sy;
    int p;
    sx = $signed(x);
    sy = $signed(y);
    p  = sx * sy;
    return p[PW-1:0];
`else
    int p;
    p = int'(x) * int'(y);
    return p[PW-1:0];
`endif
  endfunction

  // Apply operands for one edge, then check mul against the product sampled one edge earlier.
  task automatic cycle(input logic [W-1:0] x, input logic [W-1:0] y, input string name);
    logic [PW-1:0] exp_v;
    a = x;
    b = y;
    @(posedge ck);
    exp_q.push_back(ref_mul(x, y));
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mul !== exp_v) begin
      errors++;
      $display("FAIL %s: a=%0d b=%0d mul=%h expected=%h", name, x, y, mul, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = '0;
    b = '0;
    #2;
    checks++;
    if (mul !== '0) begin
      errors++;
      $display("FAIL reset_initial: mul=%h expected=00", mul);
    end
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      @(posedge ck);
      #1;
      checks++;
      if (mul !== '0) begin
        errors++;
        $display("FAIL reset_hold: edge=%0d mul=%h expected=00", i, mul);
      end
    end
    @(negedge ck);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    for (int i = 0; i < 6; i++) begin
      cycle(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "reset_release");
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] xs[4] = '{4'd2, 4'd6, 4'd1, 4'd5};
    logic [W-1:0] ys[4] = '{4'd5, 4'd4, 4'd7, 4'd3};
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 5; c++) begin
        cycle(xs[s], ys[s], "hold");
      end
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] xs[4] = '{4'd15, 4'd0, 4'd15, 4'd8};
    logic [W-1:0] ys[4] = '{4'd15, 4'd15, 4'd1, 4'd8};
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        cycle(xs[s], ys[s], "corner");
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(4'd3, 4'd3, "b2b");
    cycle(4'd4, 4'd4, "b2b");
    cycle(4'd5, 4'd5, "b2b");
    for (int i = 0; i < 60; i++) begin
      cycle(W'($urandom), W'($urandom), "b2b_random");
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) begin
      cycle(4'd6, 4'd4, "pre_reset");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mul !== '0) begin
      errors++;
      $display("FAIL async_reset_immediate: mul=%h expected=00", mul);
    end
    @(posedge ck);
    #1;
    checks++;
    if (mul !== '0) begin
      errors++;
      $display("FAIL async_reset_hold: mul=%h expected=00", mul);
    end
    @(negedge ck);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back('0);
    cycle(4'd7, 4'd3, "post_reset");
    cycle(4'd2, 4'd9, "post_reset");
    cycle(4'd2, 4'd9, "post_reset");
  endtask

  task automatic test_examples();
    logic [PW-1:0] exp_88;
    logic [PW-1:0] exp_f7;
    exp_88 = 8'h40;
`ifdef NEW_MUL_SIGNED_EN
    exp_f7 = 8'hF9;
`else
    exp_f7 = 8'h69;
`endif
    cycle(4'b1000, 4'b1000, "example_88");
    cycle(4'b1111, 4'b0111, "example_f7");
    checks++;
    if (mul !== exp_88) begin
      errors++;
      $display("FAIL example_88_const: mul=%h expected=%h", mul, exp_88);
    end
    cycle(4'b1111, 4'b0111, "example_f7");
    checks++;
    if (mul !== exp_f7) begin
      errors++;
      $display("FAIL example_f7_const: mul=%h expected=%h", mul, exp_f7);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_corners();
    test_back_to_back();
    test_async_reset();
    test_examples();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
